// File: rtl/sha2_ipu_pkg.sv
// Shared constants and state encodings for the SHA-2 input-processing unit.
// The datapath mux and the control FSM both import this package.
package sha2_ipu_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned LAST_IDX = 7;
  localparam int unsigned PKT_W    = 64;

  localparam logic [PKT_W-1:0] PAD_WORD = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    DATA = 3'd0,
    PAD  = 3'd1,
    ZERO = 3'd2,
    MGLN = 3'd3,
    HOLD = 3'd4,
    FIN  = 3'd5
  } state_e;

  // Where HOLD resumes once the block has been consumed.
  typedef enum logic [1:0] {
    RET_DATA = 2'd0,
    RET_PAD  = 2'd1,
    RET_ZERO = 2'd2,
    RET_FIN  = 2'd3
  } ret_e;

  function automatic state_e ret_to_state(input ret_e r);
    case (r)
      RET_PAD:  return PAD;
      RET_ZERO: return ZERO;
      RET_FIN:  return FIN;
      default:  return DATA;
    endcase
  endfunction

endpackage

// File: rtl/sha2_ipu_ctrl.sv
// Control FSM for the SHA-2 input-processing unit: accepts message packets,
// strobes pad/zero/length inserts into the datapath and releases 512-bit blocks.
module sha2_ipu_ctrl #(
  parameter int unsigned IDX_W    = sha2_ipu_pkg::IDX_W,
  parameter int unsigned LAST_IDX = sha2_ipu_pkg::LAST_IDX
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             pkt_valid,
  input  logic             pkt_last,
  output logic             pkt_ready,
  input  logic [IDX_W-1:0] idx,
  output logic             st_pkt,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             mgln_pkt,
  output logic             clr,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             msg_done
);
  import sha2_ipu_pkg::*;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(LAST_IDX - 1);

  state_e state_q, state_d;
  ret_e   ret_q, ret_d;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      DATA: begin
        // pkt_ready is always high here, so pkt_valid alone marks the handshake
        if (pkt_valid) begin
          if (idx == IDX_LAST) begin
            state_d = HOLD;
            ret_d   = pkt_last ? RET_PAD : RET_DATA;
          end else if (pkt_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (idx == IDX_LAST) begin
          state_d = HOLD;
          ret_d   = RET_ZERO;
        end else if (idx == IDX_PENULT) begin
          state_d = MGLN;
        end else begin
          state_d = ZERO;
        end
      end
      ZERO: begin
        if (idx == IDX_PENULT) state_d = MGLN;
      end
      MGLN: begin
        state_d = HOLD;
        ret_d   = RET_FIN;
      end
      HOLD: begin
        if (blk_ready) state_d = ret_to_state(ret_q);
      end
      FIN:     state_d = DATA;
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= DATA;
      ret_q   <= RET_DATA;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Outputs decode the held state; reset forces them all low.
  always_comb begin
    pkt_ready = 1'b0;
    st_pkt    = 1'b0;
    pad_pkt   = 1'b0;
    zero_pkt  = 1'b0;
    mgln_pkt  = 1'b0;
    clr       = 1'b0;
    blk_valid = 1'b0;
    msg_done  = 1'b0;
    if (!rst_b) begin
      case (state_q)
        DATA: begin
          pkt_ready = 1'b1;
          st_pkt    = pkt_valid;
        end
        PAD: begin
          st_pkt  = 1'b1;
          pad_pkt = 1'b1;
        end
        ZERO: begin
          st_pkt   = 1'b1;
          zero_pkt = 1'b1;
        end
        MGLN: begin
          st_pkt   = 1'b1;
          mgln_pkt = 1'b1;
        end
        HOLD: blk_valid = 1'b1;
        FIN: begin
          clr      = 1'b1;
          msg_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha2_ipu_ctrl.md
Name: sha2_ipu_ctrl

Overview:
Control FSM that sequences the SHA-2 input-processing-unit datapath (packet mux, length register, 3-bit packet counter, 8x64 register file).
- Accepts a stream of 64-bit message packets with a valid/ready/last handshake.
- Generates the store, pad, zero and length-insert strobes needed to build padded 512-bit blocks.
- Presents each completed block to the compression stage with a valid/ready handshake.
- Clears the datapath at the end of each message.

Parameters:
- IDX_W, 3, width of the datapath packet index; a block holds 2**IDX_W = 8 packets.
- LAST_IDX, 7, index of the final packet slot in a block; this slot holds the length packet.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  reset, synchronous and active-high.
- pkt_valid  in  1  upstream has a message packet on the datapath pkt bus.
- pkt_last  in  1  qualifies pkt_valid: this packet is the final one of the message.
- pkt_ready  out  1  controller accepts a packet this cycle.
- idx  in  IDX_W  current datapath packet index (counter output).
- st_pkt  out  1  datapath store strobe; the counter increments on it.
- pad_pkt  out  1  selects the 0x8000_0000_0000_0000 pad packet.
- zero_pkt  out  1  selects the all-zero packet.
- mgln_pkt  out  1  selects the message-length packet.
- clr  out  1  clears the datapath length register and counter.
- blk_valid  out  1  the 512-bit blk bus holds a complete block.
- blk_ready  in  1  downstream consumes the block.
- msg_done  out  1  one-cycle pulse when the final block of a message has been consumed.

Behaviour:
- States: DATA (reset state), PAD, ZERO, MGLN, HOLD, FIN. A 2-bit `ret` register stores the state to return to after HOLD (values DATA, PAD, ZERO, FIN).
- While rst_b=1, all outputs are 0. On the first edge with rst_b=0: state=DATA, ret=DATA.
- All outputs are Moore decodes of the state, except st_pkt in DATA, which is pkt_valid & pkt_ready. The packet is stored on the same edge as the handshake (zero latency).
- DATA:
  - pkt_ready=1; st_pkt=pkt_valid.
  - On a handshake with idx==LAST_IDX: go to HOLD; ret=PAD if pkt_last, else DATA.
  - Else on a handshake with pkt_last: go to PAD.
  - Else stay in DATA.
- PAD:
  - st_pkt=1, pad_pkt=1.
  - idx==LAST_IDX: go to HOLD, ret=ZERO. There is no room for the length in this block.
  - idx==LAST_IDX-1: go to MGLN.
  - Otherwise: go to ZERO.
- ZERO: st_pkt=1, zero_pkt=1. idx==LAST_IDX-1: go to MGLN; otherwise stay in ZERO.
- MGLN: st_pkt=1, mgln_pkt=1. idx is always LAST_IDX here. Go to HOLD, ret=FIN.
- HOLD:
  - blk_valid=1, pkt_ready=0, st_pkt=0. The register file and counter are frozen.
  - On blk_ready: go to ret. Otherwise stay; blk_valid must hold until consumed.
- FIN: clr=1, msg_done=1 for exactly one cycle, then go to DATA.
- Only one of pad_pkt, zero_pkt, mgln_pkt is ever high at a time. pad/zero/mgln are never asserted without st_pkt.
- pkt_last is ignored unless pkt_valid & pkt_ready. Zero-length messages are not supported; every message has at least one data packet.
- Message-length field = 64 x (number of data packets). It is produced by the datapath length register, which counts data stores only.
- pkt_ready=0 in PAD/ZERO/MGLN/HOLD/FIN. Upstream must hold pkt_valid and packet data stable until accepted.
- Reset asserted mid-message (any state): the next state is DATA with outputs 0 during reset. The datapath is reset by the same rst_b. No partial block or msg_done is emitted.
- Illegal or unreachable state encodings recover to DATA on the next edge.
- idx is sampled combinationally. The controller never drives st_pkt in HOLD, so the idx wrap from 7 to 0 occurs only on the store of slot 7.

Decomposition:
- Shared package sha2_ipu_pkg holds:
  - the state enum (DATA, PAD, ZERO, MGLN, HOLD, FIN);
  - IDX_W and LAST_IDX;
  - the PAD_WORD constant 64'h8000_0000_0000_0000, shared with the datapath mux;
  - the packet width 64.
- No sub-module: a single FSM. A top-level wrapper instantiates sha2_ipu_ctrl alongside the datapath.

Test Plan:
- 1-packet message, blk_ready tied 1:
  - data at idx0, pad at idx1, zero at idx2..6, mgln at idx7;
  - blk_valid for 1 cycle with blk[63:0]=64;
  - msg_done 1 cycle later;
  - 10 cycles total from the handshake.
- 7-packet message:
  - pad at idx7; first block released with no length;
  - second block: zeros at idx0..6, mgln=448 (0x1C0) at idx7;
  - two blk_valid pulses, one msg_done.
- 8-packet message:
  - first block is pure data;
  - second block: pad at idx0, zeros at idx1..6, length 512 at idx7.
- blk_ready held 0 for 5 cycles in HOLD:
  - blk_valid stays 1, pkt_ready=0, st_pkt=0, idx unchanged;
  - release proceeds exactly as with no stall.
- pkt_valid gaps (valid 1,0,0,1,1 with last on the 3rd packet): only 3 stores, length 192.
- Back-to-back messages, then rst_b=1 for 1 cycle while in ZERO:
  - the clr pulse separates messages and the second message's length restarts at 64;
  - after reset: state DATA, pkt_ready=1, no msg_done.
